// File: rtl/fp_add_rr_scheduler.sv
// Round-robin scheduler sharing one fixed-latency SIMD FP adder among NUM_REQ requesters.
// Requests are granted only while a response slot is guaranteed (credit > 0). Each grant is
// registered onto the adder inputs, and its {ID, CONFIG} tag is tracked through a LAT-deep
// pipe. The adder result is captured into a show-ahead response FIFO when the tag emerges.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid / req_ready           per-requester request / one-hot grant
//   req_in1, req_in2                packed operands, requester i at [i*DATA_W +: DATA_W]
//   req_config, req_round           packed per-requester CONFIG_FP / ROUND_TYPE
//   add_valid, add_in1, add_in2,
//   add_config, add_round           registered issue to the adder
//   add_out                         adder result, aligned with tag stage LAT-1
//   rsp_valid / rsp_ready           response FIFO head handshake
//   rsp_data, rsp_id, rsp_config    head result, requester ID and config
//   busy                            work in flight or buffered
module fp_add_rr_scheduler #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ID_W       = 2,
   parameter int unsigned LAT        = 3,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned CFG_W      = 3,
   parameter int unsigned RND_W      = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]  req_in1,
   input  logic [NUM_REQ*DATA_W-1:0]  req_in2,
   input  logic [NUM_REQ*CFG_W-1:0]   req_config,
   input  logic [NUM_REQ*RND_W-1:0]   req_round,
   output logic                       add_valid,
   output logic [DATA_W-1:0]          add_in1,
   output logic [DATA_W-1:0]          add_in2,
   output logic [CFG_W-1:0]           add_config,
   output logic [RND_W-1:0]           add_round,
   input  logic [DATA_W-1:0]          add_out,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [DATA_W-1:0]          rsp_data,
   output logic [ID_W-1:0]            rsp_id,
   output logic [CFG_W-1:0]           rsp_config,
   output logic                       busy
);

   localparam int unsigned CRD_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CRD_W-1:0]  credit_q, credit_d;
   logic [ID_W-1:0]   cand;
   logic [ID_W-1:0]   grant_id;
   logic              grant_found;
   logic              handshake;
   logic              pop;
   logic [DATA_W-1:0] sel_in1, sel_in2;
   logic [CFG_W-1:0]  sel_cfg;
   logic [RND_W-1:0]  sel_rnd;

   logic [LAT-1:0]            tag_valid_q;
   logic [LAT-1:0][ID_W-1:0]  tag_id_q;
   logic [LAT-1:0][CFG_W-1:0] tag_cfg_q;

   logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
   logic [ID_W-1:0]   mem_id   [FIFO_DEPTH];
   logic [CFG_W-1:0]  mem_cfg  [FIFO_DEPTH];
   logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
   logic              fifo_wr, fifo_empty, fifo_full;

   // First valid requester at or after the RR pointer, with wrap.
   always_comb begin
      cand        = '0;
      grant_id    = '0;
      grant_found = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_id    = cand;
         end
      end
      req_ready = '0;
      // Gated by rst_n so no grant is visible while reset is held.
      if (rst_n && grant_found && (credit_q != '0)) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   assign handshake = |(req_valid & req_ready);
   assign pop       = rsp_valid & rsp_ready;

   always_comb begin
      sel_in1 = req_in1[32'(grant_id) * DATA_W +: DATA_W];
      sel_in2 = req_in2[32'(grant_id) * DATA_W +: DATA_W];
      sel_cfg = req_config[32'(grant_id) * CFG_W +: CFG_W];
      sel_rnd = req_round[32'(grant_id) * RND_W +: RND_W];
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (handshake) begin
         rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
      case ({handshake, pop})
         2'b10:   credit_d = credit_q - 1'b1;
         2'b01:   credit_d = credit_q + 1'b1;
         default: credit_d = credit_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q   <= '0;
         credit_q   <= CRD_W'(FIFO_DEPTH);
         add_valid  <= 1'b0;
         add_in1    <= '0;
         add_in2    <= '0;
         add_config <= '0;
         add_round  <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         credit_q  <= credit_d;
         add_valid <= handshake;
         if (handshake) begin
            add_in1    <= sel_in1;
            add_in2    <= sel_in2;
            add_config <= sel_cfg;
            add_round  <= sel_rnd;
         end
      end
   end

   // Tag stage 0 becomes valid together with add_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_valid_q <= '0;
         tag_id_q    <= '0;
         tag_cfg_q   <= '0;
      end else begin
         tag_valid_q[0] <= handshake;
         tag_id_q[0]    <= grant_id;
         tag_cfg_q[0]   <= sel_cfg;
         for (int unsigned k = 1; k < LAT; k++) begin
            tag_valid_q[k] <= tag_valid_q[k-1];
            tag_id_q[k]    <= tag_id_q[k-1];
            tag_cfg_q[k]   <= tag_cfg_q[k-1];
         end
      end
   end

   assign fifo_wr    = tag_valid_q[LAT-1];
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = ((wr_ptr_q - rd_ptr_q) == (PTR_W + 1)'(FIFO_DEPTH));

   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         mem_data[wr_ptr_q[PTR_W-1:0]] <= add_out;
         mem_id[wr_ptr_q[PTR_W-1:0]]   <= tag_id_q[LAT-1];
         mem_cfg[wr_ptr_q[PTR_W-1:0]]  <= tag_cfg_q[LAT-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Head fields read as zero when empty so reset leaves every response output at 0.
   assign rsp_valid  = !fifo_empty;
   assign rsp_data   = fifo_empty ? '0 : mem_data[rd_ptr_q[PTR_W-1:0]];
   assign rsp_id     = fifo_empty ? '0 : mem_id[rd_ptr_q[PTR_W-1:0]];
   assign rsp_config = fifo_empty ? '0 : mem_cfg[rd_ptr_q[PTR_W-1:0]];
   assign busy       = (|tag_valid_q) | !fifo_empty;

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(fifo_wr && fifo_full && !pop));
   a_credit_range : assert property (@(posedge clk) disable iff (!rst_n)
      credit_q <= CRD_W'(FIFO_DEPTH));
   a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(req_ready));

endmodule
